// File: rtl/muldiv_pkg.sv
// Shared constants for the execute-stage mul/div sequencer: FSM encoding,
// request opcode bit positions and the fast divide-by-zero LO value.
package muldiv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int OP_DIV_BIT  = 1;
  localparam int OP_SIGN_BIT = 0;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_sched.sv
// Sequencer for the iterative multiplier/divider: latches operands, holds begin,
// captures HI/LO until consumed. Define MULDIV_DIV0_FAST_EN to short-cut divide-by-zero.
module muldiv_sched
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        req_ready,
  input  logic        flush,
  output logic        mult_begin,
  output logic        mult_sign,
  output logic [31:0] mult_op1,
  output logic [31:0] mult_op2,
  input  logic [63:0] product,
  input  logic        mult_end,
  output logic        div_begin,
  output logic        div_sign,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic [31:0] div_result,
  input  logic [31:0] div_remainder,
  input  logic        div_end,
  output logic        resp_valid,
  output logic [31:0] resp_hi,
  output logic [31:0] resp_lo,
  input  logic        resp_ready,
  output logic        busy
);

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic        sign_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        accept;
  logic        is_div;
  logic        div0_fast;

  assign accept = req_valid & req_ready & ~flush;
  assign is_div = req_op[OP_DIV_BIT];

`ifdef MULDIV_DIV0_FAST_EN
  assign div0_fast = is_div & (req_src2 == 32'd0);
`else
  assign div0_fast = 1'b0;
`endif

  always_comb begin
    // NOTE: assigning a default before any branch keeps this block purely
    // combinational; a path that leaves state_nx unassigned would infer a latch.
    state_nx = state;
    if (flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept)     state_nx = div0_fast ? ST_DONE : (is_div ? ST_DIV : ST_MUL);
        ST_MUL:  if (mult_end)   state_nx = ST_DONE;
        ST_DIV:  if (div_end)    state_nx = ST_DONE;
        ST_DONE: if (resp_ready) state_nx = ST_IDLE;
        default:                 state_nx = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is checked only on the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      op1_q  <= 32'd0;
      op2_q  <= 32'd0;
      sign_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op1_q  <= req_src1;
        op2_q  <= req_src2;
        sign_q <= req_op[OP_SIGN_BIT];
        if (div0_fast) begin
          hi_q <= req_src1;
          lo_q <= DIV0_LO;
        end
      end
      // Flush discards a completing result; stray *_end pulses are ignored by state match.
      if (!flush && state == ST_MUL && mult_end) begin
        hi_q <= product[63:32];
        lo_q <= product[31:0];
      end
      if (!flush && state == ST_DIV && div_end) begin
        hi_q <= div_remainder;
        lo_q <= div_result;
      end
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign resp_valid = (state == ST_DONE);
  assign mult_begin = (state == ST_MUL) & ~flush;
  assign div_begin  = (state == ST_DIV) & ~flush;

  assign mult_sign = sign_q;
  assign mult_op1  = op1_q;
  assign mult_op2  = op2_q;
  assign div_sign  = sign_q;
  assign div_op1   = op1_q;
  assign div_op2   = op2_q;
  assign resp_hi   = hi_q;
  assign resp_lo   = lo_q;

endmodule
